// File: rtl/pwm_pkg.sv
// Purpose: shared constants and helpers for the multi-channel PWM generator.
//   addr_top / addr_pol : config address of the TOP and polarity registers
//   TOP_RESET           : reset value of TOP (truncated to WIDTH by the user)
//   prescale_tick       : 1 when the low 'speed' bits of the prescaler are all ones
package pwm_pkg;

    localparam int unsigned TICK_W = 32;
    localparam logic [TICK_W-1:0] TOP_RESET = '1;

    // TOP sits right after the duty registers
    function automatic int unsigned addr_top(input int unsigned channels);
        return channels;
    endfunction

    // Polarity mask sits right after TOP
    function automatic int unsigned addr_pol(input int unsigned channels);
        return channels + 1;
    endfunction

    // speed=0 gives an empty mask, so the tick fires every cycle
    function automatic logic prescale_tick(input logic [TICK_W-1:0] pre_cnt,
                                           input logic [4:0]        speed);
        logic [TICK_W-1:0] mask;
        mask = (TICK_W'(1) << speed) - TICK_W'(1);
        return (pre_cnt & mask) == mask;
    endfunction

endpackage

// File: rtl/pwm_channel.sv
// Purpose: one PWM output channel with double-buffered duty and a polarity bit.
// Ports:
//   clk, rst_n  : clock, synchronous active-low reset
//   ena_i       : run enable; low drives the idle (polarity) level
//   load_i      : copy pending duty into active duty this cycle
//   wr_duty_i   : accepted write to this channel's duty register
//   wr_pol_i    : accepted write to the polarity mask
//   data_i      : config write data
//   pol_i       : this channel's bit of the polarity write data
//   cnt_i       : shared period counter
//   pwm_o       : registered PWM output
module pwm_channel #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena_i,
    input  logic             load_i,
    input  logic             wr_duty_i,
    input  logic             wr_pol_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pol_i,
    input  logic [WIDTH-1:0] cnt_i,
    output logic             pwm_o
);

    logic [WIDTH-1:0] duty_pend_q, duty_pend_d;
    logic [WIDTH-1:0] duty_act_q,  duty_act_d;
    logic             pol_q, pol_d;
    logic             pwm_q, pwm_d;

    // Loading from duty_pend_d lets a write landing on the load cycle win
    always_comb begin
        duty_pend_d = wr_duty_i ? data_i : duty_pend_q;
        duty_act_d  = load_i ? duty_pend_d : duty_act_q;
        pol_d       = wr_pol_i ? pol_i : pol_q;
        pwm_d       = ena_i ? ((cnt_i < duty_act_q) ^ pol_q) : pol_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            duty_pend_q <= '0;
            duty_act_q  <= '0;
            pol_q       <= 1'b0;
            pwm_q       <= 1'b0;
        end else begin
            duty_pend_q <= duty_pend_d;
            duty_act_q  <= duty_act_d;
            pol_q       <= pol_d;
            pwm_q       <= pwm_d;
        end
    end

    assign pwm_o = pwm_q;

endmodule

// File: rtl/pwm_multichan.sv
// Purpose: multi-channel PWM generator with a shared prescaler and period counter.
// Ports:
//   clk, rst_n     : clock, synchronous active-low reset
//   ena            : run enable; low stops the counter and idles the outputs
//   speed          : prescale select, divide by 2**speed
//   cfg_valid/ready: config write handshake
//   cfg_addr/data  : duty[0..CHANNELS-1], TOP at CHANNELS, polarity at CHANNELS+1
//   cfg_err        : 1-cycle pulse after an accepted write to an unmapped address
//   period_start   : 1-cycle pulse when the counter wraps to 0
//   pwm_out        : registered PWM outputs
module pwm_multichan
    import pwm_pkg::*;
#(
    parameter int unsigned CHANNELS = 4,
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned SPEED_W  = 3
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            ena,
    input  logic [SPEED_W-1:0]              speed,
    input  logic                            cfg_valid,
    output logic                            cfg_ready,
    input  logic [$clog2(CHANNELS+2)-1:0]   cfg_addr,
    input  logic [WIDTH-1:0]                cfg_data,
    output logic                            cfg_err,
    output logic                            period_start,
    output logic [CHANNELS-1:0]             pwm_out
);

    // Enough prescaler bits for the largest selectable divide
    localparam int unsigned PRE_W = (1 << SPEED_W) - 1;

    logic [PRE_W-1:0]    pre_cnt_q, pre_cnt_d;
    logic [WIDTH-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0]    top_pend_q, top_pend_d;
    logic [WIDTH-1:0]    top_act_q, top_act_d;
    logic                cfg_ready_q;
    logic                cfg_err_q, cfg_err_d;
    logic                period_start_q, period_start_d;

    logic                accept;
    logic                tick;
    logic                wrap;
    logic                load;
    logic                wr_top;
    logic                wr_pol;
    int unsigned         addr_idx;
    logic [CHANNELS-1:0] wr_duty;

    // Config decode
    always_comb begin
        accept   = cfg_valid && cfg_ready_q;
        addr_idx = 32'(cfg_addr);
        wr_top   = accept && (addr_idx == addr_top(CHANNELS));
        wr_pol   = accept && (addr_idx == addr_pol(CHANNELS));
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            wr_duty[i] = accept && (addr_idx == i);
        end
        cfg_err_d = accept && (addr_idx > addr_pol(CHANNELS));
    end

    // Prescaler, period counter and TOP double buffer; stopped means reload every cycle
    always_comb begin
        tick           = ena && prescale_tick(TICK_W'(pre_cnt_q), 5'(speed));
        wrap           = tick && (cnt_q >= top_act_q);
        load           = wrap || !ena;
        period_start_d = wrap;
        pre_cnt_d      = ena ? pre_cnt_q + PRE_W'(1) : '0;
        cnt_d          = cnt_q;
        if (!ena || wrap) begin
            cnt_d = '0;
        end else if (tick) begin
            cnt_d = cnt_q + WIDTH'(1);
        end
        top_pend_d = wr_top ? cfg_data : top_pend_q;
        top_act_d  = load ? top_pend_d : top_act_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pre_cnt_q      <= '0;
            cnt_q          <= '0;
            top_pend_q     <= WIDTH'(TOP_RESET);
            top_act_q      <= WIDTH'(TOP_RESET);
            cfg_ready_q    <= 1'b0;
            cfg_err_q      <= 1'b0;
            period_start_q <= 1'b0;
        end else begin
            pre_cnt_q      <= pre_cnt_d;
            cnt_q          <= cnt_d;
            top_pend_q     <= top_pend_d;
            top_act_q      <= top_act_d;
            cfg_ready_q    <= 1'b1;
            cfg_err_q      <= cfg_err_d;
            period_start_q <= period_start_d;
        end
    end

    for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_ch
        pwm_channel #(
            .WIDTH(WIDTH)
        ) u_channel (
            .clk      (clk),
            .rst_n    (rst_n),
            .ena_i    (ena),
            .load_i   (load),
            .wr_duty_i(wr_duty[ch]),
            .wr_pol_i (wr_pol),
            .data_i   (cfg_data),
            .pol_i    (cfg_data[ch]),
            .cnt_i    (cnt_q),
            .pwm_o    (pwm_out[ch])
        );
    end

    assign cfg_ready    = cfg_ready_q;
    assign cfg_err      = cfg_err_q;
    assign period_start = period_start_q;

endmodule

// File: tb/tb_pwm_multichan.sv
// Self-checking bench for pwm_multichan: directed scenarios plus a random run,
// all compared against a cycle-level behavioural model of the generator.
module tb_pwm_multichan;

    localparam int CH = 4;
    localparam int W  = 8;
    localparam int SW = 3;

    logic          clk;
    logic          rst_n;
    logic          ena;
    logic [SW-1:0] speed;
    logic          cfg_valid;
    logic          cfg_ready;
    logic [2:0]    cfg_addr;
    logic [W-1:0]  cfg_data;
    logic          cfg_err;
    logic          period_start;
    logic [CH-1:0] pwm_out;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model state
    logic [W-1:0]  m_cnt, m_top_act, m_top_pend;
    logic [W-1:0]  m_duty_act [CH];
    logic [W-1:0]  m_duty_pend[CH];
    logic [CH-1:0] m_pol, m_pwm;
    logic          m_ps, m_err, m_ready;
    int            m_run;

    pwm_multichan #(
        .CHANNELS(CH),
        .WIDTH   (W),
        .SPEED_W (SW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ena         (ena),
        .speed       (speed),
        .cfg_valid   (cfg_valid),
        .cfg_ready   (cfg_ready),
        .cfg_addr    (cfg_addr),
        .cfg_data    (cfg_data),
        .cfg_err     (cfg_err),
        .period_start(period_start),
        .pwm_out     (pwm_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Advance the model by one clock using the inputs currently applied
    task automatic model_step();
        logic          acc, tk, wr;
        int            div;
        logic [CH-1:0] nxt;
        if (!rst_n) begin
            m_ready = 0; m_err = 0; m_ps = 0; m_pwm = '0; m_cnt = '0; m_run = 0;
            m_top_act = 8'hFF; m_top_pend = 8'hFF; m_pol = '0;
            for (int i = 0; i < CH; i++) begin
                m_duty_act[i] = '0; m_duty_pend[i] = '0;
            end
            return;
        end
        acc = cfg_valid && m_ready;
        div = 1 << speed;
        // enabled cycles since the run began decide where the prescaler stands
        tk  = ena && ((m_run % div) == div - 1);
        wr  = tk && (m_cnt == m_top_act);
        for (int i = 0; i < CH; i++)
            nxt[i] = ena ? ((m_cnt < m_duty_act[i]) ^ m_pol[i]) : m_pol[i];
        m_pwm = nxt;
        m_ps  = wr;
        m_err = acc && (cfg_addr > CH + 1);
        if (acc) begin
            if (cfg_addr < CH)           m_duty_pend[cfg_addr] = cfg_data;
            else if (cfg_addr == CH)     m_top_pend = cfg_data;
            else if (cfg_addr == CH + 1) m_pol = cfg_data[CH-1:0];
        end
        if (wr || !ena) begin
            m_top_act = m_top_pend;
            for (int i = 0; i < CH; i++) m_duty_act[i] = m_duty_pend[i];
        end
        if (!ena || wr) m_cnt = '0;
        else if (tk)    m_cnt = m_cnt + 8'd1;
        m_run   = ena ? m_run + 1 : 0;
        m_ready = 1;
    endtask

    task automatic step();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input logic [2:0] addr, input logic [W-1:0] data);
        cfg_valid = 1'b1; cfg_addr = addr; cfg_data = data;
        step();
        cfg_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; ena = 1'b0; speed = '0;
        cfg_valid = 1'b0; cfg_addr = '0; cfg_data = '0;
        for (int k = 0; k < 3; k++) begin
            step();
            n_checks++;
            if ({pwm_out, period_start, cfg_err, cfg_ready} !== 7'b0) begin
                n_fail++;
                $display("FAIL reset_outputs: pwm=%b ps=%b err=%b ready=%b, expected all 0",
                         pwm_out, period_start, cfg_err, cfg_ready);
            end
        end
        rst_n = 1'b1;
        step();
        n_checks++;
        if (cfg_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_ready_rise: cfg_ready=%b expected 1", cfg_ready);
        end
    endtask

    task automatic test_basic();
        int highs = 0, starts = 0;
        ena = 1'b0; speed = 3'd0;
        step();
        cfg_write(3'd4, 8'd9);
        cfg_write(3'd0, 8'd3);
        cfg_write(3'd5, 8'd0);
        ena = 1'b1;
        for (int k = 0; k < 20; k++) begin
            step();
            n_checks++;
            if (pwm_out !== m_pwm || period_start !== m_ps) begin
                n_fail++;
                $display("FAIL basic_cycle: pwm=%b ps=%b expected %b %b", pwm_out, period_start, m_pwm, m_ps);
            end
            highs  += int'(pwm_out[0]);
            starts += int'(period_start);
        end
        n_checks++;
        if (highs != 6 || starts != 2) begin
            n_fail++;
            $display("FAIL basic_duty: highs=%0d starts=%0d expected 6 and 2", highs, starts);
        end
    endtask

    task automatic test_speed();
        int highs = 0, starts = 0;
        bit seen = 0;
        ena = 1'b0;
        step();
        speed = 3'd2;
        cfg_write(3'd4, 8'd3);
        cfg_write(3'd1, 8'd2);
        ena = 1'b1;
        for (int k = 0; k < 37; k++) begin
            step();
            n_checks++;
            if (pwm_out !== m_pwm || period_start !== m_ps) begin
                n_fail++;
                $display("FAIL speed_cycle: pwm=%b ps=%b expected %b %b", pwm_out, period_start, m_pwm, m_ps);
            end
            if (k < 32) begin
                highs  += int'(pwm_out[1]);
                starts += int'(period_start);
            end
        end
        n_checks++;
        if (highs != 16 || starts != 2) begin
            n_fail++;
            $display("FAIL speed_div4: highs=%0d starts=%0d expected 16 and 2", highs, starts);
        end
        speed = 3'd0;
        for (int k = 0; k < 5; k++) begin
            step();
            n_checks++;
            if (pwm_out !== m_pwm || period_start !== m_ps) begin
                n_fail++;
                $display("FAIL speed_switch: pwm=%b ps=%b expected %b %b", pwm_out, period_start, m_pwm, m_ps);
            end
            if (period_start) seen = 1;
        end
        n_checks++;
        if (!seen) begin
            n_fail++;
            $display("FAIL speed_switch_wrap: period_start seen=%0d expected 1", seen);
        end
    endtask

    task automatic test_midperiod();
        int highs;
        int k;
        ena = 1'b0;
        step();
        speed = 3'd0;
        cfg_write(3'd4, 8'd9);
        cfg_write(3'd0, 8'd3);
        ena = 1'b1;
        k = 0;
        while (m_cnt != 8'd4 && k < 40) begin step(); k++; end
        n_checks++;
        if (m_cnt != 8'd4) begin
            n_fail++;
            $display("FAIL mid_reach: cnt=%0d expected 4", m_cnt);
        end
        cfg_write(3'd0, 8'd7);
        highs = 0;
        for (int j = 0; j < 5; j++) begin step(); highs += int'(pwm_out[0]); end
        n_checks++;
        if (highs != 0) begin
            n_fail++;
            $display("FAIL mid_old_period: highs=%0d expected 0", highs);
        end
        highs = 0;
        for (int j = 0; j < 10; j++) begin
            step();
            highs += int'(pwm_out[0]);
            n_checks++;
            if (pwm_out !== m_pwm) begin
                n_fail++;
                $display("FAIL mid_cycle: pwm=%b expected %b", pwm_out, m_pwm);
            end
        end
        n_checks++;
        if (highs != 7) begin
            n_fail++;
            $display("FAIL mid_new_duty: highs=%0d expected 7", highs);
        end
        k = 0;
        while (m_cnt != 8'd9 && k < 40) begin step(); k++; end
        cfg_write(3'd0, 8'd5);
        highs = 0;
        for (int j = 0; j < 10; j++) begin step(); highs += int'(pwm_out[0]); end
        n_checks++;
        if (highs != 5) begin
            n_fail++;
            $display("FAIL wrap_write: highs=%0d expected 5", highs);
        end
    endtask

    task automatic test_bounds();
        ena = 1'b0;
        step();
        cfg_write(3'd5, 8'd0);
        cfg_write(3'd4, 8'd5);
        cfg_write(3'd0, 8'd0);
        cfg_write(3'd1, 8'd6);
        cfg_write(3'd2, 8'd255);
        cfg_write(3'd3, 8'($urandom_range(0, 7)));
        ena = 1'b1;
        for (int k = 0; k < 12; k++) begin
            step();
            n_checks++;
            if (pwm_out[2:0] !== 3'b110 || pwm_out !== m_pwm) begin
                n_fail++;
                $display("FAIL bounds_pol0: pwm=%b expected [2:0]=110 model %b", pwm_out, m_pwm);
            end
        end
        ena = 1'b0;
        cfg_write(3'd5, 8'h07);
        step();
        n_checks++;
        if (pwm_out !== 4'b0111) begin
            n_fail++;
            $display("FAIL bounds_idle: pwm=%b expected 0111", pwm_out);
        end
        ena = 1'b1;
        for (int k = 0; k < 12; k++) begin
            step();
            n_checks++;
            if (pwm_out[2:0] !== 3'b001 || pwm_out !== m_pwm) begin
                n_fail++;
                $display("FAIL bounds_pol1: pwm=%b expected [2:0]=001 model %b", pwm_out, m_pwm);
            end
        end
    endtask

    task automatic test_ena();
        int highs = 0;
        int k = 0;
        ena = 1'b0;
        step();
        speed = 3'd0;
        cfg_write(3'd5, 8'h0A);
        cfg_write(3'd4, 8'd9);
        cfg_write(3'd0, 8'd5);
        ena = 1'b1;
        while (m_cnt != 8'd2 && k < 40) begin step(); k++; end
        ena = 1'b0;
        step();
        n_checks++;
        if (pwm_out !== 4'b1010 || period_start !== 1'b0) begin
            n_fail++;
            $display("FAIL ena_stop: pwm=%b ps=%b expected 1010 0", pwm_out, period_start);
        end
        cfg_write(3'd0, 8'd8);
        step();
        ena = 1'b1;
        for (int j = 0; j < 10; j++) begin
            step();
            highs += int'(pwm_out[0]);
            n_checks++;
            if (pwm_out !== m_pwm || period_start !== m_ps) begin
                n_fail++;
                $display("FAIL ena_restart: pwm=%b ps=%b expected %b %b", pwm_out, period_start, m_pwm, m_ps);
            end
        end
        n_checks++;
        if (highs != 8) begin
            n_fail++;
            $display("FAIL ena_new_duty: highs=%0d expected 8", highs);
        end
    endtask

    task automatic test_err_and_reset();
        cfg_write(3'd5, 8'h05);
        step();
        cfg_write(3'd6, 8'($urandom));
        n_checks++;
        if (cfg_err !== 1'b1 || pwm_out !== m_pwm) begin
            n_fail++;
            $display("FAIL err_pulse: err=%b pwm=%b expected 1 %b", cfg_err, pwm_out, m_pwm);
        end
        step();
        n_checks++;
        if (cfg_err !== 1'b0 || pwm_out !== m_pwm) begin
            n_fail++;
            $display("FAIL err_single: err=%b pwm=%b expected 0 %b", cfg_err, pwm_out, m_pwm);
        end
        cfg_write(3'd7, 8'h00);
        n_checks++;
        if (cfg_err !== 1'b1) begin
            n_fail++;
            $display("FAIL err_addr7: err=%b expected 1", cfg_err);
        end
        step();
        step();
        rst_n = 1'b0;
        step();
        n_checks++;
        if ({pwm_out, period_start, cfg_err, cfg_ready} !== 7'b0) begin
            n_fail++;
            $display("FAIL mid_reset: pwm=%b ps=%b err=%b ready=%b expected all 0",
                     pwm_out, period_start, cfg_err, cfg_ready);
        end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_random();
        for (int k = 0; k < 2000; k++) begin
            rst_n     = ($urandom_range(0, 299) != 0);
            ena       = ($urandom_range(0, 19) != 0);
            if ($urandom_range(0, 19) == 0) speed = 3'($urandom_range(0, 3));
            cfg_valid = ($urandom_range(0, 2) == 0);
            cfg_addr  = 3'($urandom_range(0, 7));
            cfg_data  = (cfg_addr == 3'd4) ? 8'($urandom_range(0, 12)) : 8'($urandom_range(0, 16));
            step();
            n_checks++;
            if ({pwm_out, period_start, cfg_err, cfg_ready} !== {m_pwm, m_ps, m_err, m_ready}) begin
                n_fail++;
                $display("FAIL random_cycle %0d: pwm=%b ps=%b err=%b ready=%b expected %b %b %b %b",
                         k, pwm_out, period_start, cfg_err, cfg_ready, m_pwm, m_ps, m_err, m_ready);
            end
        end
        cfg_valid = 1'b0;
        rst_n     = 1'b1;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_speed();
        test_midperiod();
        test_bounds();
        test_ena();
        test_err_and_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
